nn_sequencer: RTL and testbench
===============================

# nn_sequencer

Control FSM that drives one `neural_network` instance: it streams weights and inputs into the network's memories, clears the datapath, runs the layer/node sweep, then streams the last layer's results out. It sits between a host-side valid/ready stream and the network's strobe and index ports, replacing hand-driven strobes and index counters.

## Interface
- `LAYER_SIZE`, 4, nodes per layer (≥2)
- `LAYER_DEPTH`, 4, layers (≥2)
- `BIT_SIZE`, 16, data word width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a job; sampled only in IDLE
- `skip_weights`  in  1  sampled with `start`; 1 = reuse stored weights, skip LOAD_W
- `in_data`  in  BIT_SIZE  weight/input word
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  sequencer accepts a word this cycle
- `out_data`  out  BIT_SIZE  result word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts result
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at job end
- `nn_rst`  out  1  network datapath clear
- `nn_weight_we`, `nn_input_we`  out  1  network write strobes
- `nn_input_select`  out  1  1 = network takes `nn_x` as input, 0 = feedback
- `nn_layer`  out  $clog2(LAYER_DEPTH)  layer index
- `nn_node`  out  $clog2(LAYER_SIZE)  node index
- `nn_x`  out  BIT_SIZE  word to network (= `in_data`)
- `nn_y`  in  BIT_SIZE  network memory read at (`nn_layer`,`nn_node`), combinational

## Operation
- States: IDLE → LOAD_W → LOAD_X → CLEAR → RUN → OUT → DONE → IDLE.
- IDLE: `start`=1 → LOAD_X if `skip_weights`=1, else LOAD_W. Counters zeroed.
- Beat = `in_valid && in_ready`; `in_ready`=1 only in LOAD_W/LOAD_X.
- LOAD_W: LAYER_DEPTH×LAYER_SIZE beats, node fastest, layer slowest; each beat asserts `nn_weight_we`, index = current counters. Last beat (layer D-1, node S-1) → LOAD_X.
- LOAD_X: LAYER_SIZE beats, `nn_layer`=0, `nn_input_we`=`nn_input_select`=1 per beat. Last beat → CLEAR.
- CLEAR: exactly one cycle, `nn_rst`=1, index 0 → RUN.
- RUN: `nn_input_select`=0; one (layer,node) step per cycle, no stall, D×S cycles; last step → OUT.
- OUT: `nn_layer`=D-1, `nn_node`=output counter, `out_data`=`nn_y`, `out_valid`=1; counter advances on `out_valid && out_ready`; last transfer → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE ignored. `in_valid` low stalls LOAD_*; `out_ready` low holds OUT and `out_data` stable.
- Index counters wrap explicitly at S-1 / D-1 (non-power-of-two sizes supported); no overflow into unused codes.
- Write strobes, `nn_x`, `out_data`, `in_ready`, `out_valid` combinational from state/counters/inputs; state and counters registered.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0; `in_ready`, `out_valid`, `busy`, `done`, write strobes, `nn_input_select` = 0; `nn_layer`=`nn_node`=0; `nn_rst`=1 combinationally while `rst` high, 0 after.
- `rst` mid-job: abort immediately, no `done`; next job restarts from IDLE.
- `start` in cycle 0 → first `in_ready` in cycle 1.
- Full job, `in_valid`=`out_ready`=1, S=D=4: LOAD_W 1–16, LOAD_X 17–20, CLEAR 21, RUN 22–37, OUT 38–41, `done` 42, IDLE 43.
- With `skip_weights`: LOAD_X 1–4, CLEAR 5, RUN 6–21, OUT 22–25, `done` 26.
- `start` in the DONE cycle ignored; accepted from the following IDLE cycle.

## Structure
- Package `nn_pkg`: `nn_seq_state_t` enum (IDLE, LOAD_W, LOAD_X, CLEAR, RUN, OUT, DONE); index-width localparams derived from LAYER_SIZE/LAYER_DEPTH.
- Sub-module `nn_idx_counter`: two-level (layer, node) counter with `clear`, `advance`, wrap and `last` flag; one instance shared by LOAD_W/LOAD_X/RUN/OUT.

## Test plan
- Full job, S=D=4, streams always ready, weights 1..16, inputs 17..20 → `nn_weight_we` on cycles 1–16 with (layer,node) (0,0)…(3,3); `nn_input_we` on 17–20; `nn_rst` only cycle 21; `done` cycle 42.
- `in_valid` deasserted every other cycle in LOAD_W → strobes only on beats, indices never skip, LOAD_W spans 32 cycles.
- `out_ready` low 3 cycles at OUT node 2 → `out_data` and `nn_node`=2 held, exactly 4 transfers, `done` after the last.
- `skip_weights`=1 → no `nn_weight_we` at all, `done` cycle 26.
- `rst` pulsed during RUN (cycle 30) → all outputs to reset values; new `start` completes normally with `done` 42 cycles later.
- `start` held high throughout, plus LAYER_SIZE=3 → second job starts only after DONE→IDLE; `nn_node` never exceeds 2.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding and index-width helpers for the network sequencer.
package nn_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, CLEAR, RUN, OUT, DONE} nn_seq_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    localparam int DEF_LAYER_SIZE = 4;
    localparam int DEF_LAYER_DEPTH = 4;
    localparam int DEF_NODE_W = idx_w(DEF_LAYER_SIZE);
    localparam int DEF_LAYER_W = idx_w(DEF_LAYER_DEPTH);
endpackage

// File: rtl/nn_idx_counter.sv
// nn_idx_counter: two-level (layer, node) index counter, node fastest, explicit wrap.
module nn_idx_counter
    import nn_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int DEPTH = 4,
    localparam int NW = idx_w(SIZE),
    localparam int LW = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [LW-1:0] layer,
    output logic [NW-1:0] node,
    output logic          node_last,
    output logic          last
);
    logic layer_last;
    assign node_last = node == NW'(SIZE - 1);
    assign layer_last = layer == LW'(DEPTH - 1);
    assign last = node_last && layer_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer <= '0;
            node <= '0;
        end else if (clear) begin
            layer <= '0;
            node <= '0;
        end else if (advance) begin
            node <= node_last ? '0 : node + 1'b1;
            if (node_last) layer <= layer_last ? '0 : layer + 1'b1;
        end
    end
endmodule

// File: rtl/nn_sequencer.sv
// nn_sequencer: streams weights/inputs into a neural_network, runs the sweep,
// then streams the last layer's results out over valid/ready.
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int LAYER_SIZE = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE = 16,
    localparam int NW = idx_w(LAYER_SIZE),
    localparam int LW = idx_w(LAYER_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                skip_weights,
    input  logic [BIT_SIZE-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BIT_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                nn_rst,
    output logic                nn_weight_we,
    output logic                nn_input_we,
    output logic                nn_input_select,
    output logic [LW-1:0]       nn_layer,
    output logic [NW-1:0]       nn_node,
    output logic [BIT_SIZE-1:0] nn_x,
    input  logic [BIT_SIZE-1:0] nn_y
);
    nn_seq_state_t state, next;
    logic advance, clear, node_last, last;
    logic [LW-1:0] cnt_layer;

    nn_idx_counter #(.SIZE(LAYER_SIZE), .DEPTH(LAYER_DEPTH)) idx (
        .clk(clk), .rst(rst), .clear(clear), .advance(advance),
        .layer(cnt_layer), .node(nn_node), .node_last(node_last), .last(last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        advance = 1'b0;
        case (state)
            IDLE:   if (start) next = skip_weights ? LOAD_X : LOAD_W;
            LOAD_W: begin
                advance = in_valid;
                if (in_valid && last) next = LOAD_X;
            end
            LOAD_X: begin
                advance = in_valid;
                if (in_valid && node_last) next = CLEAR;
            end
            CLEAR:  next = RUN;
            RUN: begin
                advance = 1'b1;
                if (last) next = OUT;
            end
            OUT: begin
                advance = out_ready;
                if (out_ready && node_last) next = DONE;
            end
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Every state change restarts the shared counter at (0,0).
    assign clear = (next != state) || (state == IDLE);
    assign in_ready = (state == LOAD_W) || (state == LOAD_X);
    assign nn_weight_we = (state == LOAD_W) && in_valid;
    assign nn_input_we = (state == LOAD_X) && in_valid;
    assign nn_input_select = state == LOAD_X;
    assign nn_layer = (state == OUT) ? LW'(LAYER_DEPTH - 1) : cnt_layer;
    assign nn_rst = rst || (state == CLEAR);
    assign nn_x = in_data;
    assign out_data = nn_y;
    assign out_valid = state == OUT;
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_nn_sequencer.sv
// tb_nn_sequencer: vector table plus scoreboarded job sequences for nn_sequencer.
module tb_nn_sequencer;
    localparam int S = 4, D = 4, B = 16;
    logic clk = 0;
    logic rst, start, skip_weights, in_valid, out_ready;
    logic [B-1:0] in_data, out_data, nn_x, nn_y;
    logic in_ready, out_valid, busy, done, nn_rst, nn_weight_we, nn_input_we, nn_input_select;
    logic [1:0] nn_layer, nn_node;

    logic rst2, start2, in_ready2, out_valid2, busy2, done2, nn_rst2, wwe2, xwe2, sel2;
    logic [B-1:0] out_data2, nn_x2, nn_y2;
    logic [1:0] nn_layer2, nn_node2;

    always #5 clk = ~clk;

    nn_sequencer #(.LAYER_SIZE(S), .LAYER_DEPTH(D), .BIT_SIZE(B)) dut (
        .clk(clk), .rst(rst), .start(start), .skip_weights(skip_weights),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .nn_rst(nn_rst), .nn_weight_we(nn_weight_we),
        .nn_input_we(nn_input_we), .nn_input_select(nn_input_select),
        .nn_layer(nn_layer), .nn_node(nn_node), .nn_x(nn_x), .nn_y(nn_y)
    );

    nn_sequencer #(.LAYER_SIZE(3), .LAYER_DEPTH(D), .BIT_SIZE(B)) dut3 (
        .clk(clk), .rst(rst2), .start(start2), .skip_weights(1'b0),
        .in_data(16'h0042), .in_valid(1'b1), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
        .busy(busy2), .done(done2), .nn_rst(nn_rst2), .nn_weight_we(wwe2),
        .nn_input_we(xwe2), .nn_input_select(sel2),
        .nn_layer(nn_layer2), .nn_node(nn_node2), .nn_x(nn_x2), .nn_y(nn_y2)
    );

    // Network memory stand-in: read word encodes the index it was read from.
    assign nn_y = {6'd0, nn_layer, 6'd0, nn_node} | 16'h5000;
    assign nn_y2 = {6'd0, nn_layer2, 6'd0, nn_node2} | 16'h5000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {logic x; int layer; int node; logic [B-1:0] data;} wexp_t;
    wexp_t wq[$];
    logic [B-1:0] oq[$];
    bit sb_on = 0;
    int w_first, w_last, w_cnt, x_first, x_last, x_cnt, r_cnt, r_cyc, run_cnt, o_cnt, done_cyc;
    int done_cnt = 0;

    task automatic clr();
        w_first = -1; w_last = -1; w_cnt = 0; x_first = -1; x_last = -1; x_cnt = 0;
        r_cnt = 0; r_cyc = -1; run_cnt = 0; o_cnt = 0; done_cyc = -1;
        wq.delete(); oq.delete();
    endtask

    always @(negedge clk) begin
        wexp_t e;
        logic [B-1:0] o;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (sb_on) begin
            if (nn_weight_we || nn_input_we) begin
                if (wq.size() == 0) check("spurious_we", 1, 0);
                else begin
                    e = wq.pop_front();
                    check("we_kind", {nn_input_we, nn_weight_we}, {e.x, !e.x});
                    check("we_layer", nn_layer, e.layer);
                    check("we_node", nn_node, e.node);
                    check("we_data", nn_x, e.data);
                    check("we_select", nn_input_select, e.x);
                end
                if (nn_weight_we) begin
                    if (w_first < 0) w_first = cyc;
                    w_last = cyc; w_cnt++;
                end else begin
                    if (x_first < 0) x_first = cyc;
                    x_last = cyc; x_cnt++;
                end
            end
            if (!rst && nn_rst) begin r_cnt++; r_cyc = cyc; end
            if (busy && !in_ready && !out_valid && !nn_rst && !done) begin
                run_cnt++;
                check("run_select", nn_input_select, 0);
            end
            if (out_valid && out_ready) begin
                o_cnt++;
                check("out_layer", nn_layer, D - 1);
                if (oq.size() == 0) check("spurious_out", 1, 0);
                else begin
                    o = oq.pop_front();
                    check("out_data", out_data, o);
                end
            end
        end
    end

    int max_node2 = 0, viol2 = 0, d2[$];
    bit prev_done2 = 0;
    always @(negedge clk) begin
        if (!rst2) begin
            if (int'(nn_node2) > max_node2) max_node2 = int'(nn_node2);
            if (prev_done2 && busy2) viol2++;
            if (done2) d2.push_back(cyc);
            prev_done2 = done2;
        end
    end

    task automatic feed(input bit x, input int l, input int n, input logic [B-1:0] d, input int gap);
        int k = 0;
        in_valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = d;
        in_valid = 1;
        wq.push_back('{x, l, n, d});
        @(negedge clk);
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        if (!in_ready) check("feed_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic job(input bit skip, input int wgap, output int t0);
        clr();
        sb_on = 1;
        for (int n = 0; n < S; n++) oq.push_back(16'h5000 | 16'((D - 1) << 8) | 16'(n));
        @(posedge clk); #1;
        start = 1; skip_weights = skip; t0 = cyc;
        @(posedge clk); #1;
        start = 0;
        if (!skip)
            for (int l = 0; l < D; l++)
                for (int n = 0; n < S; n++) feed(0, l, n, 16'(l * S + n + 1), wgap);
        for (int n = 0; n < S; n++) feed(1, 0, n, 16'(D * S + n + 1), 0);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cyc < 0 && k < 300) begin @(negedge clk); k++; end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic r, st, sk, v;
        logic e_busy, e_rdy, e_nnrst, e_xwe, e_wwe, e_sel;
        int e_node, e_layer;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int t0, dc, k;
        logic [B-1:0] h;
        rst = 1; start = 0; skip_weights = 0; in_valid = 0; in_data = 0; out_ready = 1;
        rst2 = 1; start2 = 1;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 2, 0};
        tbl[7]  = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 3, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0};
        repeat (2) @(posedge clk);
        #1 rst2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            rst = tbl[i].r; start = tbl[i].st; skip_weights = tbl[i].sk;
            in_valid = tbl[i].v; in_data = 16'(i);
            @(negedge clk);
            check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            check($sformatf("v%0d_nn_rst", i), nn_rst, tbl[i].e_nnrst);
            check($sformatf("v%0d_input_we", i), nn_input_we, tbl[i].e_xwe);
            check($sformatf("v%0d_weight_we", i), nn_weight_we, tbl[i].e_wwe);
            check($sformatf("v%0d_select", i), nn_input_select, tbl[i].e_sel);
            check($sformatf("v%0d_node", i), nn_node, tbl[i].e_node);
            check($sformatf("v%0d_layer", i), nn_layer, tbl[i].e_layer);
            check($sformatf("v%0d_out_valid", i), out_valid, 0);
            check($sformatf("v%0d_done", i), done, 0);
        end
        @(posedge clk); #1;
        start = 0; in_valid = 0;
        clr();
        wait_done();

        // Full job, both streams always ready.
        job(0, 0, t0);
        wait_done();
        check("full_w_first", w_first, t0 + 1);
        check("full_w_last", w_last, t0 + 16);
        check("full_w_cnt", w_cnt, 16);
        check("full_x_first", x_first, t0 + 17);
        check("full_x_last", x_last, t0 + 20);
        check("full_nn_rst_cnt", r_cnt, 1);
        check("full_nn_rst_cyc", r_cyc, t0 + 21);
        check("full_run_cycles", run_cnt, 16);
        check("full_out_cnt", o_cnt, 4);
        check("full_done_cyc", done_cyc, t0 + 42);
        @(negedge clk);
        check("full_idle_after", busy, 0);
        check("full_wq_empty", wq.size(), 0);

        // in_valid low every other cycle during LOAD_W.
        job(0, 1, t0);
        wait_done();
        check("stall_w_first", w_first, t0 + 2);
        check("stall_w_last", w_last, t0 + 32);
        check("stall_w_cnt", w_cnt, 16);
        check("stall_done_cyc", done_cyc, t0 + 58);

        // out_ready low for three cycles at OUT node 2.
        job(0, 0, t0);
        dc = done_cnt;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(out_valid && nn_node == 2) && k < 100);
        check("ostall_reach", {out_valid, 6'd0, nn_node}, {1'b1, 6'd0, 2'd2});
        out_ready = 0;
        h = out_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ostall_hold_data", out_data, h);
            check("ostall_hold_node", nn_node, 2);
            @(posedge clk); #1;
        end
        out_ready = 1;
        wait_done();
        check("ostall_out_cnt", o_cnt, 4);
        check("ostall_done_cyc", done_cyc, t0 + 45);
        check("ostall_done_once", done_cnt - dc, 1);

        // Reuse stored weights.
        job(1, 0, t0);
        wait_done();
        check("skip_w_cnt", w_cnt, 0);
        check("skip_x_first", x_first, t0 + 1);
        check("skip_nn_rst_cyc", r_cyc, t0 + 5);
        check("skip_out_cnt", o_cnt, 4);
        check("skip_done_cyc", done_cyc, t0 + 26);

        // Reset in RUN aborts the job without done.
        job(0, 0, t0);
        while (cyc < t0 + 30) begin @(posedge clk); #1; end
        dc = done_cnt;
        rst = 1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_nn_rst", nn_rst, 1);
        check("abort_outs", {in_ready, out_valid, done, nn_weight_we, nn_input_we, nn_input_select}, 0);
        check("abort_index", {nn_layer, nn_node}, 0);
        @(posedge clk); #1;
        rst = 0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_nn_rst_release", nn_rst, 0);
        job(0, 0, t0);
        wait_done();
        check("restart_done_cyc", done_cyc, t0 + 42);
        check("restart_out_cnt", o_cnt, 4);
        sb_on = 0;

        // Size-3 instance has been running back to back with start held high.
        k = 0;
        while (d2.size() < 2 && k < 200) begin @(posedge clk); k++; end
        check("s3_two_jobs", d2.size() >= 2, 1);
        if (d2.size() >= 2) check("s3_job_period", d2[1] - d2[0], 33);
        check("s3_idle_after_done", viol2, 0);
        check("s3_node_max", max_node2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
